// File: rtl/alu_result_rob_pkg.sv
// Shared types and defaults for the ALU result reorder stage.
package def;

    localparam int result_width = 32;
    localparam int tag_width    = 4;
    localparam int ROB_DEPTH    = 2**tag_width;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } rob_state_t;

    typedef struct packed {
        logic [result_width-1:0] result;
        logic                    error;
    } rob_entry_t;

endpackage

// File: rtl/alu_result_rob_tag_order_fifo.sv
// Circular FIFO of issued tags; exposes the head and the entry behind it so the
// owner can look one pop ahead when building registered outputs.
module tag_order_fifo
    import def::*;
#(
    parameter int TAG_W = tag_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [TAG_W-1:0] push_tag_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] head_o,
    output logic [TAG_W-1:0] second_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [TAG_W:0]   count_o
);

    localparam int DEPTH = 2**TAG_W;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             push_s, pop_s;

    // Pointer and count next-state; a push while full is dropped (the owner never does it).
    always_comb begin
        full_o   = (count_q == (TAG_W+1)'(DEPTH));
        empty_o  = (count_q == (TAG_W+1)'(0));
        push_s   = push_i & ~full_o;
        pop_s    = pop_i & ~empty_o;
        wr_ptr_d = push_s ? (wr_ptr_q + TAG_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + TAG_W'(1)) : rd_ptr_q;
        count_d  = count_q + (TAG_W+1)'(push_s) - (TAG_W+1)'(pop_s);
        head_o   = mem_q[rd_ptr_q];
        second_o = mem_q[rd_ptr_q + TAG_W'(1)];
        count_o  = count_q;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= TAG_W'(0);
            rd_ptr_q <= TAG_W'(0);
            count_q  <= (TAG_W+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

endmodule

// File: rtl/alu_result_rob.sv
// Reorders out-of-order ALU completions back into issue order for writeback,
// flagging tag protocol violations in a sticky error bit.
module alu_result_rob
    import def::*;
#(
    parameter int RESULT_W = result_width,
    parameter int TAG_W    = tag_width
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [TAG_W-1:0]    issue_tag,
    output logic                issue_ready,
    input  logic                cmp_valid,
    input  logic [TAG_W-1:0]    cmp_tag,
    input  logic [RESULT_W-1:0] cmp_result,
    input  logic                cmp_error,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TAG_W-1:0]    out_tag,
    output logic [RESULT_W-1:0] out_result,
    output logic                out_error,
    output logic [TAG_W:0]      occupancy,
    output logic                proto_err
);

    localparam int DEPTH = 2**TAG_W;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic                error;
    } entry_t;

    rob_state_t state_q [DEPTH];
    rob_state_t state_d [DEPTH];
    entry_t     entry_q [DEPTH];
    entry_t     entry_d [DEPTH];

    logic                out_valid_q, out_valid_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;
    logic [RESULT_W-1:0] out_result_q, out_result_d;
    logic                out_error_q, out_error_d;
    logic                proto_err_q, proto_err_d;

    logic             retire_s, tag_free_s, issue_ok_s, issue_bad_s, cmp_ok_s, cmp_bad_s;
    logic [TAG_W-1:0] head_s, second_s, head_next_s;
    logic [TAG_W:0]   count_s, count_next_s;
    logic             full_s, empty_s;

    tag_order_fifo #(.TAG_W(TAG_W)) u_order (
        .clk        (clk),
        .reset      (reset),
        .push_i     (issue_ok_s),
        .push_tag_i (issue_tag),
        .pop_i      (retire_s),
        .head_o     (head_s),
        .second_o   (second_s),
        .full_o     (full_s),
        .empty_o    (empty_s),
        .count_o    (count_s)
    );

    assign issue_ready = ~full_s;
    assign retire_s    = out_valid_q & out_ready;
    assign occupancy   = count_s;
    assign out_valid   = out_valid_q;
    assign out_tag     = out_tag_q;
    assign out_result  = out_result_q;
    assign out_error   = out_error_q;
    assign proto_err   = proto_err_q;

    // Classify this cycle's issue and completion; a tag retiring now counts as free.
    always_comb begin
        tag_free_s  = (state_q[issue_tag] == FREE) | (retire_s & (issue_tag == head_s));
        issue_ok_s  = issue_valid & issue_ready & tag_free_s;
        issue_bad_s = issue_valid & issue_ready & ~tag_free_s;
        cmp_ok_s    = cmp_valid & (state_q[cmp_tag] == PEND);
        cmp_bad_s   = cmp_valid & ~cmp_ok_s;
        proto_err_d = proto_err_q | issue_bad_s | cmp_bad_s;
    end

    // Per-tag state machine next-state; issue has priority over the retire of the same tag.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        for (int t = 0; t < DEPTH; t++) begin
            if (issue_ok_s && (issue_tag == TAG_W'(t))) begin
                state_d[t] = PEND;
                entry_d[t] = entry_q[t];
            end else if (cmp_ok_s && (cmp_tag == TAG_W'(t))) begin
                state_d[t] = DONE;
                entry_d[t] = '{result: cmp_result, error: cmp_error};
            end else if (retire_s && (head_s == TAG_W'(t))) begin
                state_d[t] = FREE;
                entry_d[t] = entry_q[t];
            end else begin
                state_d[t] = state_q[t];
                entry_d[t] = entry_q[t];
            end
        end
    end

    // Look ahead to next cycle's FIFO head so the output registers carry no extra latency.
    always_comb begin
        count_next_s = count_s + (TAG_W+1)'(issue_ok_s) - (TAG_W+1)'(retire_s);
        if (retire_s) begin
            head_next_s = (count_s > (TAG_W+1)'(1)) ? second_s : issue_tag;
        end else begin
            head_next_s = empty_s ? issue_tag : head_s;
        end
        out_valid_d = (count_next_s != (TAG_W+1)'(0)) && (state_d[head_next_s] == DONE);
        if (out_valid_d) begin
            out_tag_d    = head_next_s;
            out_result_d = entry_d[head_next_s].result;
            out_error_d  = entry_d[head_next_s].error;
        end else begin
            out_tag_d    = out_tag_q;
            out_result_d = out_result_q;
            out_error_d  = out_error_q;
        end
    end

    // Per-tag state and result storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < DEPTH; t++) begin
                state_q[t] <= FREE;
                entry_q[t] <= '{result: RESULT_W'(0), error: 1'b0};
            end
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    // Output and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_tag_q    <= TAG_W'(0);
            out_result_q <= RESULT_W'(0);
            out_error_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            out_result_q <= out_result_d;
            out_error_q  <= out_error_d;
            proto_err_q  <= proto_err_d;
        end
    end

endmodule
